// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and default coefficients
// for the parametrised symmetric FIR.
package fir_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   localparam logic [23:0] COEF_DEFAULT = {8'sd3, 8'sd2, 8'sd1};

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int sum_w(input int dw, input int cw, input int nc);
      return dw + 1 + cw + clog2(nc);
   endfunction

endpackage

// File: rtl/fir_sat.sv
// Signed saturation from IN_W down to OUT_W,
// with a flag raised whenever the value is clipped.
module fir_sat #(
   parameter int IN_W  = 19,
   parameter int OUT_W = 11
) (
   input  logic signed [IN_W-1:0]  wide,
   output logic signed [OUT_W-1:0] narrow,
   output logic                    clip
);

   generate
      if (IN_W > OUT_W) begin : g_clip
         localparam logic signed [IN_W-1:0] MAXV =
            {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
         localparam logic signed [IN_W-1:0] MINV = ~MAXV;

         always_comb begin
            narrow = wide[OUT_W-1:0];
            clip   = 1'b0;
            if (wide > MAXV) begin
               narrow = {1'b0, {(OUT_W-1){1'b1}}};
               clip   = 1'b1;
            end else if (wide < MINV) begin
               narrow = {1'b1, {(OUT_W-1){1'b0}}};
               clip   = 1'b1;
            end
         end
      end else begin : g_pass
         assign narrow = OUT_W'(wide);
         assign clip   = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/fir_sym_param.sv
// Even-length symmetric FIR, two-stage pipeline, with serial
// coefficient reload through an atomically committed shadow bank.
module fir_sym_param
   import fir_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int NTAPS  = 6,
   parameter int OUT_W  = 11,
   parameter logic [(NTAPS/2)*COEF_W-1:0] COEF_INIT = COEF_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic signed [DATA_W-1:0] x_n,
   input  logic                     s_valid,
   input  logic                     s_set_coeffs,
   output logic signed [OUT_W-1:0]  y_n,
   output logic                     y_valid,
   output logic                     y_sat,
   output logic                     coef_done
);

   localparam int NC     = NTAPS / 2;
   localparam int PRE_W  = DATA_W + 1;
   localparam int PROD_W = PRE_W + COEF_W;
   localparam int SUM_W  = sum_w(DATA_W, COEF_W, NC);
   localparam int IDX_W  = (NC > 1) ? clog2(NC) : 1;

   state_t state, state_nx;
   logic [IDX_W-1:0] idx, wr_idx;
   logic armed, accept, load_wr, commit;

   logic signed [COEF_W-1:0] coef   [NC];
   logic signed [COEF_W-1:0] shadow [NC];
   logic signed [DATA_W-1:0] tap    [NTAPS];
   logic signed [PRE_W-1:0]  pre    [NC];
   logic signed [PROD_W-1:0] prod   [NC];

   logic v0, v1;
   logic signed [SUM_W-1:0] sum;
   logic signed [OUT_W-1:0] sat_y;
   logic sat_f;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      load_wr  = 1'b0;
      wr_idx   = idx;
      unique case (state)
         IDLE: begin
            wr_idx = '0;
            if (s_set_coeffs) load_wr = armed;
            else              accept  = s_valid;
         end
         LOAD: begin
            if (s_set_coeffs) load_wr  = 1'b1;
            else              state_nx = IDLE;
         end
      endcase
      commit = load_wr && (wr_idx == IDX_W'(NC - 1));
      if (load_wr) state_nx = commit ? IDLE : LOAD;
   end

   // A commit disarms loading until s_set_coeffs is seen low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx       <= '0;
         armed     <= 1'b1;
         coef_done <= 1'b0;
         for (int k = 0; k < NC; k++) begin
            coef[k]   <= COEF_INIT[k*COEF_W +: COEF_W];
            shadow[k] <= '0;
         end
      end else begin
         coef_done <= commit;
         if (!s_set_coeffs) armed <= 1'b1;
         else if (commit)   armed <= 1'b0;
         if (load_wr) begin
            shadow[wr_idx] <= COEF_W'(x_n);
            idx            <= wr_idx + IDX_W'(1);
         end
         if (commit) begin
            for (int k = 0; k < NC; k++) begin
               if (IDX_W'(k) == wr_idx) coef[k] <= COEF_W'(x_n);
               else                     coef[k] <= shadow[k];
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NC; k++) begin
         pre[k] = PRE_W'(tap[k]) + PRE_W'(tap[NTAPS-1-k]);
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < NC; k++) begin
         sum = sum + SUM_W'(prod[k]);
      end
   end

   fir_sat #(
      .IN_W  (SUM_W),
      .OUT_W (OUT_W)
   ) u_sat (
      .wide   (sum),
      .narrow (sat_y),
      .clip   (sat_f)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NTAPS; i++) tap[i] <= '0;
         for (int k = 0; k < NC; k++) prod[k] <= '0;
         v0      <= 1'b0;
         v1      <= 1'b0;
         y_n     <= '0;
         y_valid <= 1'b0;
         y_sat   <= 1'b0;
      end else begin
         if (accept) begin
            tap[0] <= x_n;
            for (int i = 1; i < NTAPS; i++) tap[i] <= tap[i-1];
         end
         v0 <= accept;
         if (v0) begin
            for (int k = 0; k < NC; k++) begin
               prod[k] <= PROD_W'(pre[k]) * PROD_W'(coef[k]);
            end
         end
         v1      <= v0;
         y_valid <= v1;
         if (v1) begin
            y_n   <= sat_y;
            y_sat <= sat_f;
         end
      end
   end

endmodule

// File: tb/tb_fir_sym_param.sv
// Directed vector bench for fir_sym_param with default parameters:
// impulses, loads, aborts, resets, valid gaps and saturation.
module tb_fir_sym_param;

   logic clk = 1'b0;
   logic reset_n;
   logic signed [7:0] x_n;
   logic s_valid;
   logic s_set_coeffs;
   logic signed [10:0] y_n;
   logic y_valid;
   logic y_sat;
   logic coef_done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic              v;
      logic              s;
      logic signed [7:0] x;
      logic              ev;
      logic signed [10:0] ey;
      logic              es;
      logic              ed;
   } vec_t;

   vec_t q[$];

   fir_sym_param dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .x_n          (x_n),
      .s_valid      (s_valid),
      .s_set_coeffs (s_set_coeffs),
      .y_n          (y_n),
      .y_valid      (y_valid),
      .y_sat        (y_sat),
      .coef_done    (coef_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int id,
                      input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s[%0d] got %0d expected %0d",
                  nm, id, act, exp);
      end
   endtask

   function automatic void add(input logic v, input logic s,
                               input int x, input logic ev,
                               input int ey, input logic es,
                               input logic ed);
      vec_t t;
      t.v  = v;
      t.s  = s;
      t.x  = 8'(x);
      t.ev = ev;
      t.ey = 11'(ey);
      t.es = es;
      t.ed = ed;
      q.push_back(t);
   endfunction

   function automatic void add_impulse(input int c0, input int c1,
                                       input int c2);
      int e[7];
      e = '{c0, c1, c2, c2, c1, c0, 0};
      for (int k = 0; k < 9; k++) begin
         add(k <= 6, 1'b0, (k == 0) ? 1 : 0, k >= 2,
             e[(k >= 2) ? k - 2 : 0], 1'b0, 1'b0);
      end
   endfunction

   function automatic void add_load(input int a, input int b,
                                    input int c);
      add(1'b1, 1'b1, a, 1'b0, 0, 1'b0, 1'b0);
      add(1'b1, 1'b1, b, 1'b0, 0, 1'b0, 1'b0);
      add(1'b1, 1'b1, c, 1'b0, 0, 1'b0, 1'b1);
   endfunction

   task automatic run_table(input int base);
      for (int i = 0; i < q.size(); i++) begin
         s_valid      = q[i].v;
         s_set_coeffs = q[i].s;
         x_n          = q[i].x;
         @(posedge clk);
         #1;
         chk("y_valid", base + i, int'(y_valid), int'(q[i].ev));
         chk("coef_done", base + i, int'(coef_done), int'(q[i].ed));
         if (q[i].ev) begin
            chk("y_n", base + i, int'(y_n), int'(q[i].ey));
            chk("y_sat", base + i, int'(y_sat), int'(q[i].es));
         end
      end
      q.delete();
   endtask

   task automatic rst_pulse(input int id);
      s_valid      = 1'b0;
      s_set_coeffs = 1'b0;
      x_n          = '0;
      #3 reset_n = 1'b0;
      #1;
      chk("rst_y_n", id, int'(y_n), 0);
      chk("rst_y_valid", id, int'(y_valid), 0);
      chk("rst_y_sat", id, int'(y_sat), 0);
      chk("rst_coef_done", id, int'(coef_done), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n      = 1'b0;
      s_valid      = 1'b0;
      s_set_coeffs = 1'b0;
      x_n          = '0;
      #12;
      chk("init_y_n", 0, int'(y_n), 0);
      chk("init_y_valid", 0, int'(y_valid), 0);
      chk("init_y_sat", 0, int'(y_sat), 0);
      chk("init_coef_done", 0, int'(coef_done), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      add_impulse(1, 2, 3);
      add_load(4, 5, 6);
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      add_impulse(4, 5, 6);
      run_table(100);

      add(1'b1, 1'b0, 1, 1'b0, 0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0, 1'b1, 4, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0, 1'b1, 5, 1'b0, 1'b0);
      run_table(200);
      rst_pulse(1);
      add_impulse(1, 2, 3);
      run_table(300);

      add_load(4, 5, 6);
      add(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8, 1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8, 1'b0, 0, 1'b0, 1'b0);
      run_table(400);
      rst_pulse(2);
      add(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      add_impulse(1, 2, 3);
      run_table(500);

      add(1'b0, 1'b1, 9, 1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 9, 1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      add_impulse(1, 2, 3);
      run_table(600);

      add(1'b1, 1'b0, 1,  1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0,  1'b0, 0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0,  1'b1, 1, 1'b0, 1'b0);
      add(1'b1, 1'b1, 50, 1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0,  1'b1, 2, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0,  1'b0, 0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0,  1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0,  1'b1, 3, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0,  1'b1, 3, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0,  1'b0, 0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0,  1'b1, 2, 1'b0, 1'b0);
      add(1'b1, 1'b0, 0,  1'b0, 0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0,  1'b1, 1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0,  1'b1, 0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 0,  1'b0, 0, 1'b0, 1'b0);
      run_table(700);

      add_load(127, 127, 127);
      add(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      for (int c = 0; c < 18; c++) begin
         int a, m, ey;
         logic es;
         a  = c - 2;
         m  = a - 7;
         ey = 1023;
         es = 1'b1;
         if (a >= 8 && m == 3) begin
            ey = -381;
            es = 1'b0;
         end else if (a >= 8 && m >= 4) begin
            ey = -1024;
         end
         add(c < 16, 1'b0, (c < 8) ? 127 : -128, c >= 2, ey, es, 1'b0);
      end
      run_table(800);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
